// File: rtl/pacman_sprite_fetch.sv
// Pac-Man sprite fetch: maps the VGA pixel to a sprite-ROM address, runs the mouth
// animation and aligns hit/palette outputs. Define PAC_ORIENT_EN to rotate by direction.
`timescale 1ns/1ps

// state  | meaning
// CLOSED | mouth shut, frame index 0
// HALF   | mouth opening, frame index 1
// OPEN   | mouth fully open, frame index 2
// HALF_B | mouth closing, frame index 1
module pacman_sprite_fetch #(
    parameter int SPRITE_W        = 16,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       pix_valid,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic [9:0] pac_x,
    input  logic [9:0] pac_y,
    input  logic [1:0] pac_dir,
    input  logic       moving,
    output logic [9:0] rom_addr,
    input  logic [4:0] rom_data,
    output logic [4:0] pal_index,
    output logic [1:0] pal_sel,
    output logic       sprite_hit,
    output logic       out_valid
);

    localparam int              CW       = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(FRAMES_PER_STEP - 1);
    localparam logic [10:0]     BOX      = 11'(SPRITE_W);

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        HALF   = 2'd1,
        OPEN   = 2'd2,
        HALF_B = 2'd3
    } anim_t;

    anim_t         state;
    anim_t         state_adv;
    logic          step;
    logic [CW-1:0] cnt;
    logic [9:0]    sx;
    logic [9:0]    sy;
    logic [1:0]    sframe;

    function automatic logic [1:0] frame_of(input anim_t s);
        logic [1:0] f;
        case (s)
            CLOSED:  f = 2'd0;
            OPEN:    f = 2'd2;
            default: f = 2'd1;
        endcase
        return f;
    endfunction

    always_comb begin
        case (state)
            CLOSED:  state_adv = HALF;
            HALF:    state_adv = OPEN;
            OPEN:    state_adv = HALF_B;
            default: state_adv = CLOSED;
        endcase
    end

    assign step = moving && frame_tick && (cnt == CNT_LAST);

    // The snapshotted frame is taken from the post-tick state so it holds for the whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLOSED;
            cnt    <= '0;
            sframe <= 2'd0;
            sx     <= '0;
            sy     <= '0;
        end else begin
            if (!moving) begin
                cnt <= '0;
            end else if (frame_tick) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    state <= state_adv;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (frame_tick) begin
                sx     <= pac_x;
                sy     <= pac_y;
                sframe <= frame_of(step ? state_adv : state);
            end
        end
    end

    logic [10:0] px, py, bx, by;
    logic        hit_box;
    logic [3:0]  dx, dy, col, row;

    assign px = {1'b0, draw_x};
    assign py = {1'b0, draw_y};
    assign bx = {1'b0, sx};
    assign by = {1'b0, sy};

    assign hit_box = (px >= bx) && (px < bx + BOX) && (py >= by) && (py < by + BOX);
    assign dx      = draw_x[3:0] - sx[3:0];
    assign dy      = draw_y[3:0] - sy[3:0];

`ifdef PAC_ORIENT_EN
    logic [1:0] sdir;

    always_ff @(posedge clk) begin
        if (reset) begin
            sdir <= 2'd0;
        end else if (frame_tick) begin
            sdir <= pac_dir;
        end
    end

    // Bitwise inversion of a 4-bit offset is 15 minus that offset.
    always_comb begin
        col = dx;
        row = dy;
        case (sdir)
            2'd1: begin col = ~dx; row = dy; end
            2'd2: begin col = ~dy; row = dx; end
            2'd3: begin col = dy;  row = dx; end
            default: begin col = dx; row = dy; end
        endcase
    end
`else
    logic unused_dir;

    assign unused_dir = ^pac_dir;
    assign col        = dx;
    assign row        = dy;
`endif

    logic       s1_valid, s2_valid;
    logic       s1_hit, s2_hit;
    logic [1:0] s1_frame, s2_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr   <= '0;
            s1_valid   <= 1'b0;
            s1_hit     <= 1'b0;
            s1_frame   <= 2'd0;
            s2_valid   <= 1'b0;
            s2_hit     <= 1'b0;
            s2_frame   <= 2'd0;
            out_valid  <= 1'b0;
            pal_sel    <= 2'd0;
            pal_index  <= '0;
            sprite_hit <= 1'b0;
        end else begin
            if (pix_valid) begin
                rom_addr <= {sframe, row, col};
            end
            s1_valid   <= pix_valid;
            s1_hit     <= pix_valid && hit_box;
            s1_frame   <= sframe;
            s2_valid   <= s1_valid;
            s2_hit     <= s1_hit;
            s2_frame   <= s1_frame;
            out_valid  <= s2_valid;
            pal_sel    <= s2_frame;
            pal_index  <= (s2_valid && s2_hit) ? rom_data : 5'd0;
            sprite_hit <= s2_valid && s2_hit && (rom_data != 5'd0);
        end
    end

endmodule

// File: tb/tb_pacman_sprite_fetch.sv
// Bench for pacman_sprite_fetch: synchronous ROM model, 3-deep scoreboard and directed corner cases.
`timescale 1ns/1ps

module tb_pacman_sprite_fetch;
    localparam int FPS = 4;

    logic       clk = 1'b0;
    logic       reset, frame_tick, pix_valid, moving;
    logic [9:0] draw_x, draw_y, pac_x, pac_y, rom_addr;
    logic [1:0] pac_dir, pal_sel;
    logic [4:0] rom_data, pal_index;
    logic       sprite_hit, out_valid;
    bit         rom_zero;

    always #5 clk = ~clk;

    pacman_sprite_fetch #(.SPRITE_W(16), .FRAMES_PER_STEP(FPS)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .pix_valid(pix_valid),
        .draw_x(draw_x), .draw_y(draw_y), .pac_x(pac_x), .pac_y(pac_y),
        .pac_dir(pac_dir), .moving(moving), .rom_addr(rom_addr), .rom_data(rom_data),
        .pal_index(pal_index), .pal_sel(pal_sel), .sprite_hit(sprite_hit), .out_valid(out_valid)
    );

    function automatic logic [4:0] rom_fn(input logic [9:0] a);
        return ((a[4:0] * 5'd7) ^ a[9:5]) | 5'd1;
    endfunction

    always_ff @(posedge clk) rom_data <= rom_zero ? 5'd0 : rom_fn(rom_addr);

    typedef struct {
        bit         valid;
        bit         chk_sel;
        logic [4:0] idx;
        logic [1:0] sel;
        bit         hit;
    } exp_t;

    typedef struct {
        int dir;
        int col;
        int row;
    } orient_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    int         n_pac_x, n_pac_y, n_dir;
    bit         n_moving, n_rom_zero;
    int         m_sx, m_sy, m_dir, m_st, m_cnt, m_frame;
    logic [9:0] m_addr;
    bit         armed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int frame_of(input int s);
        return (s == 0) ? 0 : ((s == 2) ? 2 : 1);
    endfunction

    task automatic cycle(input bit rst, input bit tick, input bit pv, input int x, input int y);
        exp_t e, z;
        int dx, dy, col, row, a;
        bit hit;
        logic [4:0] d;
        @(negedge clk);
        if (armed) chk("rom_addr", int'(rom_addr), int'(m_addr));
        if (sbq.size() == 3) begin
            e = sbq.pop_front();
            chk("out_valid", int'(out_valid), int'(e.valid));
            chk("pal_index", int'(pal_index), int'(e.idx));
            chk("sprite_hit", int'(sprite_hit), int'(e.hit));
            if (e.chk_sel) chk("pal_sel", int'(pal_sel), int'(e.sel));
        end
        reset = rst; frame_tick = tick; pix_valid = pv;
        draw_x = 10'(x); draw_y = 10'(y);
        pac_x = 10'(n_pac_x); pac_y = 10'(n_pac_y); pac_dir = 2'(n_dir);
        moving = n_moving; rom_zero = n_rom_zero;
        z.valid = 0; z.chk_sel = 1; z.idx = 0; z.sel = 0; z.hit = 0;
        if (rst) begin
            foreach (sbq[i]) sbq[i] = z;
            sbq.push_back(z);
            m_sx = 0; m_sy = 0; m_dir = 0; m_st = 0; m_cnt = 0; m_frame = 0;
            m_addr = '0;
        end else begin
            hit = (x >= m_sx) && (x < m_sx + 16) && (y >= m_sy) && (y < m_sy + 16);
            dx = (x - m_sx) & 15;
            dy = (y - m_sy) & 15;
            col = dx; row = dy;
`ifdef PAC_ORIENT_EN
            if (m_dir == 1) begin col = 15 - dx; row = dy; end
            if (m_dir == 2) begin col = 15 - dy; row = dx; end
            if (m_dir == 3) begin col = dy;      row = dx; end
`endif
            a = m_frame * 256 + row * 16 + col;
            d = n_rom_zero ? 5'd0 : rom_fn(10'(a));
            e.valid = pv; e.chk_sel = pv; e.sel = 2'(m_frame);
            e.idx = (pv && hit) ? d : 5'd0;
            e.hit = pv && hit && (d != 0);
            sbq.push_back(e);
            if (pv) m_addr = 10'(a);
            if (!n_moving) m_cnt = 0;
            else if (tick) begin
                if (m_cnt == FPS - 1) begin m_cnt = 0; m_st = (m_st + 1) % 4; end
                else m_cnt++;
            end
            if (tick) begin
                m_sx = n_pac_x; m_sy = n_pac_y; m_dir = n_dir; m_frame = frame_of(m_st);
            end
        end
        armed = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic probe_sel(input string name, input int exp);
        cycle(0, 0, 1, 105, 55);
        idle(3);
        chk(name, int'(pal_sel), exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        orient_t otab[4];
        int      anim_exp[5];
        int      edge_x[6];
`ifdef PAC_ORIENT_EN
        otab[0] = '{0, 2, 5};
        otab[1] = '{1, 13, 5};
        otab[2] = '{2, 10, 2};
        otab[3] = '{3, 5, 2};
`else
        otab[0] = '{0, 2, 5};
        otab[1] = '{1, 2, 5};
        otab[2] = '{2, 2, 5};
        otab[3] = '{3, 2, 5};
`endif
        anim_exp = '{1, 2, 1, 0, 1};
        edge_x   = '{630, 635, 639, 0, 3, 5};

        n_pac_x = 0; n_pac_y = 0; n_dir = 0; n_moving = 0; n_rom_zero = 0;
        reset = 1; frame_tick = 0; pix_valid = 0; draw_x = 0; draw_y = 0;
        pac_x = 0; pac_y = 0; pac_dir = 0; moving = 0; rom_zero = 0;

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_sel", int'(pal_sel), 0);
        idle(3);

        // Latency / box scan on row 53
        n_pac_x = 100; n_pac_y = 50; n_dir = 0;
        cycle(0, 1, 0, 0, 0);
        idle(1);
        for (int x = 98; x <= 118; x++) begin
            cycle(0, 0, 1, x, 53);
            if (x - 1 >= 100 && x - 1 <= 115) chk("scan_addr", int'(rom_addr), 3 * 16 + (x - 1 - 100));
        end
        idle(4);

        // Orientation table
        for (int i = 0; i < 4; i++) begin
            n_dir = otab[i].dir; n_pac_x = 200; n_pac_y = 100;
            cycle(0, 1, 0, 0, 0);
            cycle(0, 0, 1, 202, 105);
            idle(1);
            chk("orient_col", int'(rom_addr[3:0]), otab[i].col);
            chk("orient_row", int'(rom_addr[7:4]), otab[i].row);
        end
        idle(3);

        // Transparency
        n_rom_zero = 1;
        idle(1);
        cycle(0, 0, 1, 203, 104);
        idle(3);
        chk("transp_valid", int'(out_valid), 1);
        chk("transp_hit", int'(sprite_hit), 0);
        chk("transp_index", int'(pal_index), 0);
        n_rom_zero = 0;
        idle(1);

        // Right screen edge: no wrap to the left columns
        n_dir = 0; n_pac_x = 630; n_pac_y = 200;
        cycle(0, 1, 0, 0, 0);
        for (int x = 630; x <= 639; x++) cycle(0, 0, 1, x, 205);
        for (int x = 0; x <= 5; x++) cycle(0, 0, 1, x, 205);
        idle(3);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 1, edge_x[i], 205);
            idle(3);
            chk("edge_hit", int'(sprite_hit), (edge_x[i] >= 630) ? 1 : 0);
        end

        // Snapshot timing
        n_pac_x = 100; n_pac_y = 50;
        cycle(0, 1, 0, 0, 0);
        n_pac_x = 200;
        cycle(0, 0, 1, 102, 53);
        idle(1);
        chk("snap_mid_col", int'(rom_addr[3:0]), 2);
        chk("snap_mid_row", int'(rom_addr[7:4]), 3);
        n_pac_x = 300;
        cycle(0, 1, 1, 104, 53);
        idle(1);
        chk("snap_coinc_col", int'(rom_addr[3:0]), 4);
        cycle(0, 0, 1, 305, 53);
        idle(1);
        chk("snap_new_col", int'(rom_addr[3:0]), 5);
        idle(3);

        // Animation
        n_pac_x = 100; n_pac_y = 50; n_moving = 1;
        for (int s = 0; s < 5; s++) begin
            for (int t = 0; t < 4; t++) begin cycle(0, 1, 0, 0, 0); idle(1); end
            probe_sel("anim_sel", anim_exp[s]);
        end
        for (int t = 0; t < 2; t++) begin cycle(0, 1, 0, 0, 0); idle(1); end
        n_moving = 0;
        idle(1);
        for (int t = 0; t < 3; t++) begin cycle(0, 1, 0, 0, 0); idle(1); end
        probe_sel("anim_hold", 1);
        n_moving = 1;
        for (int t = 0; t < 3; t++) begin cycle(0, 1, 0, 0, 0); idle(1); end
        probe_sel("anim_restart", 1);
        cycle(0, 1, 0, 0, 0);
        idle(1);
        probe_sel("anim_after", 2);
        n_moving = 0;

        // Mid-stream reset
        cycle(0, 0, 1, 101, 52);
        cycle(0, 0, 1, 102, 52);
        cycle(1, 0, 1, 103, 52);
        cycle(1, 0, 0, 0, 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_pal_index", int'(pal_index), 0);
        chk("rst_sprite_hit", int'(sprite_hit), 0);
        chk("rst_pal_sel", int'(pal_sel), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        idle(3);
        chk("post_rst_sel", int'(pal_sel), 0);
        chk("post_rst_addr", int'(rom_addr), 0);
        cycle(0, 0, 1, 3, 4);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
